amo_unit: RTL and testbench
===========================

# amo_unit

Memory-side responder for the A extension, placed between the core's data-bus initiator and the RAM bus. Plain loads and stores pass straight through. AMO requests (funct5 encoded as `AMOOp`) are executed as a locked read-modify-write sequence on the RAM side. The block also holds the single LR/SC reservation and returns the AMO result to the core over the same response channel.

## Interface
- `DATA_WIDTH`, default `MEMBUS_DATA_WIDTH` (64): bus data width.
- `MASK_WIDTH`, default `DATA_WIDTH/8` (8): byte-enable width.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, synchronous, active-high.
- `c_valid`  in  1  core request valid.
- `c_ready`  out  1  request accepted when `c_valid && c_ready`.
- `c_addr`  in  `XLEN`  byte address (`Addr`).
- `c_wen`  in  1  write request (non-AMO only).
- `c_wdata`  in  `DATA_WIDTH`  store data, or AMO rs2 operand (low 32 bits for .W).
- `c_wmask`  in  `MASK_WIDTH`  byte enables (non-AMO only).
- `c_is_amo`  in  1  request is an AMO.
- `c_amoop`  in  5  `AMOOp`.
- `c_is_word`  in  1  1 selects .W (funct3 010), 0 selects .D (funct3 011).
- `c_rvalid`  out  1  response valid, one-cycle pulse.
- `c_rdata`  out  `DATA_WIDTH`  response data.
- `m_valid`, `m_ready`, `m_addr`, `m_wen`, `m_wdata`, `m_wmask`, `m_rvalid`, `m_rdata`: RAM-side mirror of the core bus; this block is the initiator on this side.

## Operation
**Bus contract**
- The core keeps at most one request outstanding.
- AMO addresses are naturally aligned; misalignment traps in the core before issue.
- RAM asserts `m_rvalid` exactly once per accepted request, reads and writes alike.

**States:** IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP.

**IDLE, non-AMO request**
- Combinational passthrough: `m_valid = c_valid & ~c_is_amo`, `c_ready = m_ready`.
- `m_*` mirror the `c_*` request fields.
- `c_rvalid`/`c_rdata` mirror `m_rvalid`/`m_rdata`.

**IDLE, AMO request**
- `c_ready = 1`, `m_valid = 0`.
- Latch addr, op, rs2, and width.
- Next state: LR → RD_REQ. SC with reservation hit → WR_REQ. SC with miss → RESP with result 1. All other ops → RD_REQ.

**Sequence states**
- RD_REQ: `m_valid = 1`, `m_wen = 0`, `m_addr = {addr[XLEN-1:3], 3'b0}`. Hold until `m_ready`, then go to RD_WAIT.
- RD_WAIT: on `m_rvalid`, capture the old value.
  - .W: select lane `addr[2]` and sign-extend 32→64.
  - LR: set reservation {valid, `addr[XLEN-1:3]`}, then go to RESP.
  - Otherwise go to WR_REQ.
- WR_REQ: `m_valid = 1`, `m_wen = 1`.
  - `m_wdata` = new value replicated into both 32-bit lanes (.W) or the full 64 bits (.D).
  - `m_wmask` = `8'h0F` (`addr[2]=0`), `8'hF0` (`addr[2]=1`), or `8'hFF` (.D).
  - Hold until `m_ready`, then go to WR_WAIT.
- WR_WAIT: on `m_rvalid`, go to RESP. The write-ack data is discarded.
- RESP: `c_rvalid = 1`, `c_rdata = result`, then go to IDLE.
  - Result is the old value for AMO*/LR, 0 for SC success, 1 for SC failure.

**New value**
- SWAP: rs2. ADD: wrapping add. XOR / AND / OR: bitwise.
- MIN/MAX: signed compare. MINU/MAXU: unsigned compare.
- Compare width is 32 for .W (operands are the low words) and 64 for .D.

**Reservation**
- Cleared by reset.
- Cleared by every SC, pass or fail.
- Cleared by any passthrough write accepted to the same doubleword address.
- A new LR overwrites it.

**Outputs outside IDLE:** `c_ready = 0`. `m_valid` is asserted only in RD_REQ and WR_REQ.

## Timing
- **Reset:** state IDLE, reservation invalid, latched registers 0. Registered `c_rvalid` = 0 and `m_valid` = 0. Reset mid-sequence abandons the RMW; a RAM response returning after reset is ignored.
- **Passthrough:** zero added latency.
- **AMO latency**, with `m_ready = 1` and RAM `m_rvalid` one cycle after accept (accept = cycle 0):
  - AMO: `c_rvalid` at cycle 5.
  - LR: cycle 3.
  - SC success: cycle 3.
  - SC failure: cycle 1.
- **Backpressure:** each cycle of `m_ready = 0` in RD_REQ or WR_REQ adds one cycle; the request stays stable while waiting.
- **No interleaving:** no other request reaches RAM between the read and write of an AMO.

## Structure
- Reuse `AMOOp`, `Addr`, `UIntX`, and `MEMBUS_DATA_WIDTH` from `eei`.
- Add `MEMBUS_MASK_WIDTH` to `eei`.
- The state enum stays local to the module.
- Sub-module `amo_alu`: purely combinational (op, is_word, old, rs2) → new value. It is reused later by a cache-side AMO path.

## Test plan
- Passthrough: store `0x1122334455667788` to `0x8000_0010` mask FF, then load → `c_rdata = 0x1122334455667788`, zero added latency.
- AMOADD.D at `0x8000_0010`, mem = 5, rs2 = `-3` → `c_rdata` = 5, mem = 2, `c_rvalid` at cycle 5.
- AMOMIN.W vs AMOMINU.W at `0x8000_0014` (upper lane), mem word = `0xFFFF_FFFF`, rs2 = 1:
  - MIN: mem stays `0xFFFF_FFFF`, `c_rdata = 0xFFFF_FFFF_FFFF_FFFF`, wmask F0.
  - MINU: mem becomes 1.
- LR.D at `0x8000_0020`, then SC.D with rs2 = 9 → `c_rdata` = 0, mem = 9. A second SC → `c_rdata` = 1, no RAM write, response at cycle 1.
- LR, then passthrough store to `0x8000_0024`, then SC to `0x8000_0020` → SC fails.
- Hold `m_ready = 0` for 3 cycles in WR_REQ, then assert reset mid-sequence → all outputs return to reset values, a late `m_rvalid` is ignored, and the next passthrough works.

Source files
------------

// File: rtl/eei_pkg.sv
// Shared execution-environment types: XLEN, bus widths and the A-extension funct5 encoding.
package eei;

    localparam int XLEN              = 64;
    localparam int MEMBUS_DATA_WIDTH = 64;
    localparam int MEMBUS_MASK_WIDTH = MEMBUS_DATA_WIDTH / 8;

    typedef logic [XLEN-1:0] Addr;
    typedef logic [XLEN-1:0] UIntX;

    // funct5 field of the AMO instruction word
    typedef enum logic [4:0] {
        AMO_ADD  = 5'b00000,
        AMO_SWAP = 5'b00001,
        AMO_LR   = 5'b00010,
        AMO_SC   = 5'b00011,
        AMO_XOR  = 5'b00100,
        AMO_OR   = 5'b01000,
        AMO_AND  = 5'b01100,
        AMO_MIN  = 5'b10000,
        AMO_MAX  = 5'b10100,
        AMO_MINU = 5'b11000,
        AMO_MAXU = 5'b11100
    } AMOOp;

endpackage

// File: rtl/amo_alu.sv
// Combinational AMO combine: (op, width, old memory value, rs2) -> value to store.
// For .W only the low 32 bits of the result are meaningful; the caller places them.
module amo_alu
    import eei::*;
(
    input  AMOOp       op_i,
    input  logic       is_word_i,
    input  UIntX       old_i,
    input  UIntX       rs2_i,
    output UIntX       new_o
);

    logic [31:0] old_w;
    logic [31:0] rs2_w;
    logic [31:0] add_w;
    logic        lt_s;
    logic        lt_u;

    assign old_w = old_i[31:0];
    assign rs2_w = rs2_i[31:0];
    assign add_w = old_w + rs2_w;

    // Compare at the operation width so .W min/max see the low words only
    always_comb begin
        if (is_word_i) begin
            lt_s = $signed(old_w) < $signed(rs2_w);
            lt_u = old_w < rs2_w;
        end else begin
            lt_s = $signed(old_i) < $signed(rs2_i);
            lt_u = old_i < rs2_i;
        end
    end

    // Select the new value; SC stores rs2 just like SWAP, LR leaves memory alone
    always_comb begin
        new_o = old_i;
        case (op_i)
            AMO_SWAP, AMO_SC: new_o = rs2_i;
            AMO_ADD:          new_o = is_word_i ? {{32{add_w[31]}}, add_w} : old_i + rs2_i;
            AMO_XOR:          new_o = old_i ^ rs2_i;
            AMO_AND:          new_o = old_i & rs2_i;
            AMO_OR:           new_o = old_i | rs2_i;
            AMO_MIN:          new_o = lt_s ? old_i : rs2_i;
            AMO_MAX:          new_o = lt_s ? rs2_i : old_i;
            AMO_MINU:         new_o = lt_u ? old_i : rs2_i;
            AMO_MAXU:         new_o = lt_u ? rs2_i : old_i;
            default:          new_o = old_i;
        endcase
    end

endmodule

// File: rtl/amo_unit.sv
// Memory-side AMO responder: passes plain loads/stores through, runs AMOs as a
// locked read-modify-write on the RAM bus and holds the single LR/SC reservation.
module amo_unit
    import eei::*;
#(
    parameter int DATA_WIDTH = MEMBUS_DATA_WIDTH,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  c_valid,
    output logic                  c_ready,
    input  Addr                   c_addr,
    input  logic                  c_wen,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    input  logic [MASK_WIDTH-1:0] c_wmask,
    input  logic                  c_is_amo,
    input  AMOOp                  c_amoop,
    input  logic                  c_is_word,
    output logic                  c_rvalid,
    output logic [DATA_WIDTH-1:0] c_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output Addr                   m_addr,
    output logic                  m_wen,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [MASK_WIDTH-1:0] m_wmask,
    input  logic                  m_rvalid,
    input  logic [DATA_WIDTH-1:0] m_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [XLEN-1:2]     addr_q, addr_d;
    AMOOp                op_q, op_d;
    UIntX                rs2_q, rs2_d;
    logic                word_q, word_d;
    UIntX                res_q, res_d;
    logic                rsv_v_q, rsv_v_d;
    logic [XLEN-1:3]     rsv_a_q, rsv_a_d;
    // A passthrough is in flight; RAM responses are only forwarded while set,
    // so a response to a request abandoned by reset never reaches the core.
    logic                pt_pend_q, pt_pend_d;

    UIntX                new_val;
    logic [31:0]         rd_lane;
    logic                rsv_hit;

    amo_alu u_alu (
        .op_i      (op_q),
        .is_word_i (word_q),
        .old_i     (res_q),
        .rs2_i     (rs2_q),
        .new_o     (new_val)
    );

    assign rd_lane = addr_q[2] ? m_rdata[63:32] : m_rdata[31:0];
    assign rsv_hit = rsv_v_q && (c_addr[XLEN-1:3] == rsv_a_q);

    // State and latched operands
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            op_q      <= AMO_ADD;
            rs2_q     <= '0;
            word_q    <= 1'b0;
            res_q     <= '0;
            rsv_v_q   <= 1'b0;
            rsv_a_q   <= '0;
            pt_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            op_q      <= op_d;
            rs2_q     <= rs2_d;
            word_q    <= word_d;
            res_q     <= res_d;
            rsv_v_q   <= rsv_v_d;
            rsv_a_q   <= rsv_a_d;
            pt_pend_q <= pt_pend_d;
        end
    end

    // Next state, bus outputs and reservation tracking
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        op_d      = op_q;
        rs2_d     = rs2_q;
        word_d    = word_q;
        res_d     = res_q;
        rsv_v_d   = rsv_v_q;
        rsv_a_d   = rsv_a_q;
        pt_pend_d = pt_pend_q;
        c_ready   = 1'b0;
        c_rvalid  = 1'b0;
        c_rdata   = res_q;
        m_valid   = 1'b0;
        m_addr    = {addr_q[XLEN-1:3], 3'b000};
        m_wen     = 1'b0;
        m_wdata   = word_q ? {2{new_val[31:0]}} : new_val;
        m_wmask   = word_q ? (addr_q[2] ? 8'hF0 : 8'h0F) : 8'hFF;

        case (state_q)
            S_IDLE: begin
                m_addr   = c_addr;
                m_wen    = c_wen;
                m_wdata  = c_wdata;
                m_wmask  = c_wmask;
                m_valid  = c_valid & ~c_is_amo;
                c_rvalid = m_rvalid & pt_pend_q;
                c_rdata  = m_rdata;
                if (m_rvalid) pt_pend_d = 1'b0;
                if (c_is_amo) begin
                    c_ready = 1'b1;
                    if (c_valid) begin
                        addr_d = c_addr[XLEN-1:2];
                        op_d   = c_amoop;
                        rs2_d  = c_wdata;
                        word_d = c_is_word;
                        if (c_amoop == AMO_SC) begin
                            rsv_v_d = 1'b0;
                            res_d   = rsv_hit ? '0 : UIntX'(1);
                            state_d = rsv_hit ? S_WR_REQ : S_RESP;
                        end else begin
                            state_d = S_RD_REQ;
                        end
                    end
                end else begin
                    c_ready = m_ready;
                    if (c_valid && m_ready) begin
                        pt_pend_d = 1'b1;
                        if (c_wen && rsv_hit) rsv_v_d = 1'b0;
                    end
                end
            end
            S_RD_REQ: begin
                m_valid = 1'b1;
                if (m_ready) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (m_rvalid) begin
                    res_d = word_q ? {{32{rd_lane[31]}}, rd_lane} : m_rdata;
                    if (op_q == AMO_LR) begin
                        rsv_v_d = 1'b1;
                        rsv_a_d = addr_q[XLEN-1:3];
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WR_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                m_valid = 1'b1;
                m_wen   = 1'b1;
                if (m_ready) state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (m_rvalid) state_d = S_RESP;
            end
            S_RESP: begin
                c_rvalid = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_amo_unit.sv
// Directed bench for amo_unit with a one-cycle-latency RAM model.
module tb_amo_unit;
    import eei::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_valid, c_ready, c_wen, c_is_amo, c_is_word, c_rvalid;
    Addr         c_addr;
    logic [63:0] c_wdata, c_rdata;
    logic [7:0]  c_wmask;
    AMOOp        c_amoop;
    logic        m_valid, m_ready, m_wen, m_rvalid;
    Addr         m_addr;
    logic [63:0] m_wdata, m_rdata;
    logic [7:0]  m_wmask;

    logic [63:0] mem [0:15];
    logic        ram_ready, ram_rvalid, inj_rvalid;
    logic [63:0] ram_rdata;
    logic [7:0]  last_wmask;
    int          wr_cnt = 0;
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign m_ready = ram_ready;
    assign m_rvalid = ram_rvalid | inj_rvalid;
    assign m_rdata  = ram_rdata;

    amo_unit dut (
        .clk(clk), .rst(rst),
        .c_valid(c_valid), .c_ready(c_ready), .c_addr(c_addr), .c_wen(c_wen),
        .c_wdata(c_wdata), .c_wmask(c_wmask), .c_is_amo(c_is_amo), .c_amoop(c_amoop),
        .c_is_word(c_is_word), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wen(m_wen),
        .m_wdata(m_wdata), .m_wmask(m_wmask), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    // RAM: one response per accepted request, one cycle later
    always @(posedge clk) begin
        ram_rvalid <= 1'b0;
        if (m_valid && m_ready) begin
            ram_rvalid <= 1'b1;
            if (m_wen) begin
                for (int b = 0; b < 8; b++)
                    if (m_wmask[b]) mem[m_addr[6:3]][b*8 +: 8] <= m_wdata[b*8 +: 8];
                last_wmask <= m_wmask;
                wr_cnt     <= wr_cnt + 1;
            end else begin
                ram_rdata <= mem[m_addr[6:3]];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pt(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [7:0] mask, output logic [63:0] rd, output int lat);
        @(negedge clk);
        c_valid = 1'b1; c_is_amo = 1'b0; c_wen = wen;
        c_addr = addr; c_wdata = wdata; c_wmask = mask;
        rd = '0; lat = -1;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (c_rvalid) begin rd = c_rdata; lat = n; end
            c_valid = 1'b0;
            if (lat > 0) break;
        end
    endtask

    task automatic amo(input AMOOp op, input logic word, input logic [63:0] addr,
                       input logic [63:0] rs2, output logic [63:0] rd, output int lat);
        @(negedge clk);
        c_valid = 1'b1; c_is_amo = 1'b1; c_amoop = op; c_is_word = word;
        c_addr = addr; c_wdata = rs2; c_wen = 1'b0; c_wmask = '0;
        rd = '0; lat = -1;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (c_rvalid) begin rd = c_rdata; lat = n; end
            c_valid = 1'b0;
            if (lat > 0) break;
        end
        c_is_amo = 1'b0;
    endtask

    logic [63:0] rd;
    int          lat;
    int          wc;

    initial begin
        rst = 1'b1; c_valid = 1'b0; c_is_amo = 1'b0; c_wen = 1'b0; c_is_word = 1'b0;
        c_addr = '0; c_wdata = '0; c_wmask = '0; c_amoop = AMO_ADD;
        ram_ready = 1'b1; inj_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_m_valid", m_valid, 0);

        // passthrough store then load
        pt(1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, rd, lat);
        chk("pt_st_lat", lat, 1);
        pt(1'b0, 64'h8000_0010, 64'h0, 8'hFF, rd, lat);
        chk("pt_ld_data", rd, 64'h1122_3344_5566_7788);
        chk("pt_ld_lat", lat, 1);

        // AMOADD.D: 5 + (-3)
        pt(1'b1, 64'h8000_0010, 64'd5, 8'hFF, rd, lat);
        amo(AMO_ADD, 1'b0, 64'h8000_0010, -64'sd3, rd, lat);
        chk("add_rdata", rd, 64'd5);
        chk("add_lat", lat, 5);
        chk("add_mem", mem[2], 64'd2);

        // MIN.W / MINU.W on upper lane
        pt(1'b1, 64'h8000_0010, 64'hFFFF_FFFF_0000_00AA, 8'hFF, rd, lat);
        amo(AMO_MIN, 1'b1, 64'h8000_0014, 64'd1, rd, lat);
        chk("minw_rdata", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("minw_mem", mem[2], 64'hFFFF_FFFF_0000_00AA);
        chk("minw_wmask", last_wmask, 8'hF0);
        amo(AMO_MINU, 1'b1, 64'h8000_0014, 64'd1, rd, lat);
        chk("minuw_rdata", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("minuw_mem", mem[2], 64'h0000_0001_0000_00AA);

        // SWAP.W / MAX.W on lower lane
        amo(AMO_MAX, 1'b1, 64'h8000_0010, 64'h8000_0000, rd, lat);
        chk("maxw_rdata", rd, 64'h0000_0000_0000_00AA);
        chk("maxw_mem", mem[2], 64'h0000_0001_0000_00AA);
        amo(AMO_SWAP, 1'b1, 64'h8000_0010, 64'h1234_5678, rd, lat);
        chk("swapw_rdata", rd, 64'h0000_0000_0000_00AA);
        chk("swapw_mem", mem[2], 64'h0000_0001_1234_5678);
        chk("swapw_wmask", last_wmask, 8'h0F);

        // LR / SC success / SC failure
        pt(1'b1, 64'h8000_0020, 64'h77, 8'hFF, rd, lat);
        amo(AMO_LR, 1'b0, 64'h8000_0020, 64'd0, rd, lat);
        chk("lr_rdata", rd, 64'h77);
        chk("lr_lat", lat, 3);
        amo(AMO_SC, 1'b0, 64'h8000_0020, 64'd9, rd, lat);
        chk("sc_ok_rdata", rd, 64'd0);
        chk("sc_ok_lat", lat, 3);
        chk("sc_ok_mem", mem[4], 64'd9);
        wc = wr_cnt;
        amo(AMO_SC, 1'b0, 64'h8000_0020, 64'd11, rd, lat);
        chk("sc_2nd_rdata", rd, 64'd1);
        chk("sc_2nd_lat", lat, 1);
        chk("sc_2nd_nowr", wr_cnt, wc);
        chk("sc_2nd_mem", mem[4], 64'd9);

        // store to same doubleword kills the reservation
        amo(AMO_LR, 1'b0, 64'h8000_0020, 64'd0, rd, lat);
        pt(1'b1, 64'h8000_0024, 64'hDEAD_BEEF_0000_0000, 8'hF0, rd, lat);
        amo(AMO_SC, 1'b0, 64'h8000_0020, 64'h55, rd, lat);
        chk("sc_kill_rdata", rd, 64'd1);
        chk("sc_kill_mem", mem[4], 64'hDEAD_BEEF_0000_0009);

        // backpressure in WR_REQ, then reset mid-sequence
        pt(1'b1, 64'h8000_0010, 64'h10, 8'hFF, rd, lat);
        @(negedge clk);
        c_valid = 1'b1; c_is_amo = 1'b1; c_amoop = AMO_ADD; c_is_word = 1'b0;
        c_addr = 64'h8000_0010; c_wdata = 64'd5;
        @(negedge clk); c_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); ram_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("bp_m_valid", m_valid, 1);
            chk("bp_m_wen", m_wen, 1);
            chk("bp_m_wdata", m_wdata, 64'h15);
            chk("bp_m_addr", m_addr, 64'h8000_0010);
            chk("bp_m_wmask", m_wmask, 8'hFF);
        end
        @(negedge clk); rst = 1'b1; c_is_amo = 1'b0;
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rr_m_valid", m_valid, 0);
        chk("rr_c_rvalid", c_rvalid, 0);
        chk("rr_c_ready", c_ready, 0);
        inj_rvalid = 1'b1;
        #1;
        chk("rr_late_rvalid", c_rvalid, 0);
        @(negedge clk); inj_rvalid = 1'b0; ram_ready = 1'b1;
        chk("rr_mem", mem[2], 64'h10);
        pt(1'b0, 64'h8000_0010, 64'h0, 8'hFF, rd, lat);
        chk("rr_pt_data", rd, 64'h10);
        chk("rr_pt_lat", lat, 1);
        amo(AMO_SC, 1'b0, 64'h8000_0020, 64'd3, rd, lat);
        chk("rr_sc_rdata", rd, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
